// File: rtl/mem_ctrl_burst.sv
// rtl/mem_ctrl_burst.sv - burst command front end sequencing single-byte SRAM-style accesses
module mem_ctrl_burst #(
  parameter int ADDR_W      = 16,
  parameter int MAX_BURST   = 8,
  parameter int WAIT_STATES = 0,
  parameter int LEN_W       = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   write,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BURST-1:0] wdata,
  output logic [8*MAX_BURST-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_ce,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata
);

  localparam int               DW      = 8 * MAX_BURST;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [3:0]       WC_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t           state;
  logic             lat_write;
  logic [LEN_W-1:0] lat_len;
  logic [DW-1:0]    wsh;       // latched write bytes, shifted so byte idx sits in [7:0]
  logic [LEN_W-1:0] idx;
  logic [3:0]       wc;
  logic [LEN_W-1:0] len_clamped;
  logic [DW-1:0]    wsh_next;

  // Oversized lengths saturate at the widest burst the packed data can carry
  always_comb begin
    len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  end

  // Write bytes for the following access, ready in [7:0]
  always_comb begin
    wsh_next = wsh >> 8;
  end

  // Command FSM; every memory-side output is registered so address and data move on one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lat_write <= 1'b0;
      lat_len   <= '0;
      wsh       <= '0;
      idx       <= '0;
      wc        <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy   <= 1'b0;
          mem_ce <= 1'b0;
          if (req) begin
            lat_write <= write;
            lat_len   <= len_clamped;
            wsh       <= wdata;
            idx       <= '0;
            wc        <= '0;
            busy      <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= wdata[7:0];
            if (len_clamped != '0) begin
              state  <= S_ACCESS;
              mem_ce <= 1'b1;
              mem_we <= write;
              if (!write) begin
                rdata <= '0;
              end
            end else begin
              // A no-op skips the memory entirely and completes on the next cycle
              state  <= S_DONE;
              mem_we <= 1'b0;
              done   <= 1'b1;
            end
          end
        end

        S_ACCESS: begin
          if (wc == WC_LAST) begin
            if (!lat_write) begin
              for (int i = 0; i < MAX_BURST; i++) begin
                if (idx == LEN_W'(i)) begin
                  rdata[8*i +: 8] <= mem_rdata;
                end
              end
            end
            if (idx == lat_len - LEN_W'(1)) begin
              state  <= S_DONE;
              mem_ce <= 1'b0;
              mem_we <= 1'b0;
              done   <= 1'b1;
            end else begin
              // Next byte starts immediately; the address wraps naturally at 2^ADDR_W
              idx       <= idx + LEN_W'(1);
              wc        <= '0;
              mem_addr  <= mem_addr + ADDR_W'(1);
              wsh       <= wsh_next;
              mem_wdata <= wsh_next[7:0];
            end
          end else begin
            wc <= wc + 4'd1;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          mem_ce <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// tb/tb_mem_ctrl_burst.sv - randomized scoreboard bench for mem_ctrl_burst
module tb_mem_ctrl_burst;

  localparam int AW = 16;
  localparam int MB = 8;
  localparam int WS = 2;
  localparam int LW = 4;
  localparam int DW = 8 * MB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy, done, mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_ctrl_burst #(.ADDR_W(AW), .MAX_BURST(MB), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req(req), .write(write), .addr(addr), .len(len),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .mem_ce(mem_ce),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: returns the low address byte only once the address has been held WS+1 cycles
  int            age = 0;
  logic          prev_ce = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (mem_ce && prev_ce && mem_addr == prev_addr) age <= age + 1;
    else age <= 0;
    prev_ce   <= mem_ce;
    prev_addr <= mem_addr;
  end
  assign mem_rdata = (mem_ce && age == WS) ? mem_addr[7:0] : 8'hEE;

  typedef struct {logic we; logic [AW-1:0] a; logic [7:0] d;} acc_t;
  typedef struct {int cyc; logic [DW-1:0] rd;} dn_t;

  acc_t          acc_q[$];
  dn_t           dn_q[$];
  acc_t          mon_a;
  dn_t           mon_d;
  int            n_chk = 0;
  int            n_pass = 0;
  int            edge_cnt = 0;
  int            next_free = 0;
  int            cur_e = 1;
  int            cur_d = 0;
  logic [DW-1:0] model_rd = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
  endfunction

  // Reference: a command expands into a per-cycle access list and one completion record
  function automatic void accept(int e, logic w, logic [AW-1:0] a, logic [LW-1:0] l, logic [DW-1:0] d);
    int n;
    acc_t x;
    dn_t y;
    logic [AW-1:0] ai;
    n = (int'(l) > MB) ? MB : int'(l);
    if (!w && n > 0) model_rd = '0;
    for (int i = 0; i < n; i++) begin
      ai = a + AW'(i);
      for (int k = 0; k <= WS; k++) begin
        x.we = w; x.a = ai; x.d = d[8*i +: 8];
        acc_q.push_back(x);
      end
      if (!w) model_rd[8*i +: 8] = ai[7:0];
    end
    y.cyc = e + n * (WS + 1);
    y.rd  = model_rd;
    dn_q.push_back(y);
    cur_e = e;
    cur_d = y.cyc;
    next_free = y.cyc + 2;
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      check("busy", 64'(busy), 64'(edge_cnt >= cur_e && edge_cnt <= cur_d));
      if (mem_ce) begin
        if (acc_q.size() == 0) check("unexpected_access", 64'(1), 64'(0));
        else begin
          mon_a = acc_q.pop_front();
          check("mem_we", 64'(mem_we), 64'(mon_a.we));
          check("mem_addr", 64'(mem_addr), 64'(mon_a.a));
          if (mon_a.we) check("mem_wdata", 64'(mem_wdata), 64'(mon_a.d));
        end
      end
      if (done) begin
        if (dn_q.size() == 0) check("unexpected_done", 64'(1), 64'(0));
        else begin
          mon_d = dn_q.pop_front();
          check("done_cycle", 64'(edge_cnt), 64'(mon_d.cyc));
          check("rdata", 64'(rdata), 64'(mon_d.rd));
        end
      end else if (dn_q.size() != 0 && edge_cnt >= dn_q[0].cyc) begin
        check("done_missing", 64'(0), 64'(1));
        mon_d = dn_q.pop_front();
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [LW-1:0] l, input logic [DW-1:0] d);
    req = r; write = w; addr = a; len = l; wdata = d;
    if (r && edge_cnt + 1 >= next_free) accept(edge_cnt + 1, w, a, l, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom), AW'($urandom), LW'($urandom), {$urandom, $urandom});
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (edge_cnt + 1 < next_free && b < 100) begin
      idle(1);
      b++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_mem_ce", 64'(mem_ce), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    step(1'b1, 1'b1, 16'h1000, 4'd1, 64'h00000000000000A5);
    drain();
    step(1'b1, 1'b0, 16'h2000, 4'd4, {$urandom, $urandom});
    drain();
    step(1'b1, 1'b0, 16'h3000, 4'd0, {$urandom, $urandom});
    drain();
    step(1'b1, 1'b0, 16'hFFFE, 4'd12, {$urandom, $urandom});
    drain();
    step(1'b1, 1'b1, 16'hFFFE, 4'd12, {$urandom, $urandom});
    drain();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, AW'($urandom), 4'd3, {$urandom, $urandom});
    idle(1);
    drain();

    step(1'b1, 1'b0, 16'h4000, 4'd8, {$urandom, $urandom});
    idle(5);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_mem_ce", 64'(mem_ce), 64'(0));
    check("abort_rdata", 64'(rdata), 64'(0));
    acc_q.delete();
    dn_q.delete();
    model_rd = '0;
    cur_e = 1;
    cur_d = 0;
    next_free = 0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    step(1'b1, 1'b0, 16'h5000, 4'd2, {$urandom, $urandom});
    drain();

    repeat (120) begin
      int hold;
      hold = $urandom_range(1, 3);
      repeat (hold) step(1'b1, 1'($urandom), AW'($urandom), LW'($urandom), {$urandom, $urandom});
      idle($urandom_range(0, 3));
    end
    drain();
    idle(3);
    check("acc_q_empty", 64'(acc_q.size()), 64'(0));
    check("dn_q_empty", 64'(dn_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
